// File: rtl/gol_grid_engine.sv
// Parametrised Game-of-Life engine (B3/S23) with load handshake, step/run modes and generation count.
// Optional macro GOL_AUTO_HALT_EN: stop free-running when the grid goes still or extinct.
module gol_grid_engine #(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned WRAP     = 1,
  parameter int unsigned STEP_DIV = 1,
  parameter int unsigned GEN_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [ROWS*COLS-1:0] load_data,
  input  logic                 step,
  input  logic                 run,
  output logic [ROWS*COLS-1:0] state,
  output logic                 state_valid,
  output logic [GEN_W-1:0]     generation,
  output logic                 busy,
  output logic                 still,
  output logic                 extinct,
  output logic                 halted
);

  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } fsm_t;

  fsm_t             r_fsm;
  fsm_t             w_fsm_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic [N-1:0]     r_state;
  logic [GEN_W-1:0] r_gen;
  logic             r_state_valid;
  logic             r_busy;
  logic             r_load_ready;
  logic             w_do_load;
  logic             w_do_adv;
  logic             w_blocked;

  logic [ROWS+1:0][COLS+1:0] w_pad;
  logic [N-1:0]              w_next;

  // Grid surrounded by a one-cell ring: wrapped copies on a torus, dead cells otherwise
  for (genvar gr = 0; gr < ROWS + 2; gr++) begin : g_pad_r
    for (genvar gc = 0; gc < COLS + 2; gc++) begin : g_pad_c
      localparam int unsigned SR = (gr == 0) ? ROWS - 1 : ((gr == ROWS + 1) ? 0 : gr - 1);
      localparam int unsigned SC = (gc == 0) ? COLS - 1 : ((gc == COLS + 1) ? 0 : gc - 1);
      localparam bit RING = (gr == 0) || (gr == ROWS + 1) || (gc == 0) || (gc == COLS + 1);
      if (RING && (WRAP == 0)) begin : g_dead
        assign w_pad[gr][gc] = 1'b0;
      end else begin : g_cell
        assign w_pad[gr][gc] = r_state[N-1-(SR*COLS+SC)];
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [3:0] w_cnt;
      assign w_cnt = 4'(w_pad[r][c])   + 4'(w_pad[r][c+1])   + 4'(w_pad[r][c+2])
                   + 4'(w_pad[r+1][c])                       + 4'(w_pad[r+1][c+2])
                   + 4'(w_pad[r+2][c]) + 4'(w_pad[r+2][c+1]) + 4'(w_pad[r+2][c+2]);
      assign w_next[N-1-(r*COLS+c)] = (w_cnt == 4'd3) || ((w_cnt == 4'd2) && w_pad[r+1][c+1]);
    end
  end

  assign still   = (w_next == r_state);
  assign extinct = (r_state == '0);

`ifdef GOL_AUTO_HALT_EN
  logic r_halted;
  logic r_block;
  logic w_do_halt;

  assign w_blocked = r_block;
  assign halted    = r_halted;

  // r_block holds off re-entry to RUN until run has been observed low after a halt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted <= 1'b0;
      r_block  <= 1'b0;
    end else begin
      if (w_do_load) begin
        r_halted <= 1'b0;
      end else if (w_do_halt) begin
        r_halted <= 1'b1;
      end
      if (w_do_halt) begin
        r_block <= 1'b1;
      end else if (!run || w_do_load) begin
        r_block <= 1'b0;
      end
    end
  end
`else
  assign w_blocked = 1'b0;
  assign halted    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_div_nxt = r_div;
    w_do_load = 1'b0;
    w_do_adv  = 1'b0;
`ifdef GOL_AUTO_HALT_EN
    w_do_halt = 1'b0;
`endif
    case (r_fsm)
      S_IDLE: begin
        w_div_nxt = '0;
        if (load_valid) begin
          w_do_load = 1'b1;
        end else if (run && !w_blocked) begin
          w_fsm_nxt = S_RUN;
        end else if (step) begin
          w_do_adv = 1'b1;
        end
      end
      S_RUN: begin
        if (!run) begin
          w_fsm_nxt = S_IDLE;
          w_div_nxt = '0;
        end else if (r_div == DIV_LAST) begin
          w_div_nxt = '0;
`ifdef GOL_AUTO_HALT_EN
          if (still || extinct) begin
            w_fsm_nxt = S_IDLE;
            w_do_halt = 1'b1;
          end else begin
            w_do_adv = 1'b1;
          end
`else
          w_do_adv = 1'b1;
`endif
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      default: begin
        w_fsm_nxt = S_IDLE;
        w_div_nxt = '0;
      end
    endcase
  end

  // Grid, generation count and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div         <= '0;
      r_state       <= '0;
      r_gen         <= '0;
      r_state_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_load_ready  <= 1'b1;
    end else begin
      r_div         <= w_div_nxt;
      r_state_valid <= w_do_load | w_do_adv;
      r_busy        <= (w_fsm_nxt == S_RUN);
      r_load_ready  <= (w_fsm_nxt == S_IDLE);
      if (w_do_load) begin
        r_state <= load_data;
        r_gen   <= '0;
      end else if (w_do_adv) begin
        r_state <= w_next;
        r_gen   <= r_gen + GEN_W'(1);
      end
    end
  end

  assign state       = r_state;
  assign state_valid = r_state_valid;
  assign generation  = r_gen;
  assign busy        = r_busy;
  assign load_ready  = r_load_ready;

endmodule

// File: tb/tb_gol_grid_engine.sv
// Scoreboard bench: two engines (torus/div 1/16-bit gen and dead-edge/div 4/4-bit gen) share stimulus
// and are checked against a cell-by-cell Life model; honours GOL_AUTO_HALT_EN if defined.
module tb_gol_grid_engine;

  typedef struct {
    logic [63:0] st;
    int          gen;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [63:0] load_data;
  logic        step;
  logic        run;

  logic        load_ready_a, state_valid_a, busy_a, still_a, extinct_a, halted_a;
  logic [63:0] state_a;
  logic [15:0] gen_a;
  logic        load_ready_b, state_valid_b, busy_b, still_b, extinct_b, halted_b;
  logic [63:0] state_b;
  logic [3:0]  gen_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Reference model state, one slot per engine
  int          SD[2] = '{1, 4};
  bit          WR[2] = '{1'b1, 1'b0};
  int          GM[2] = '{65535, 15};
  logic [63:0] m_state[2];
  int          m_gen[2];
  int          m_div[2];
  bit          m_run[2];
  bit          m_halted[2];
  bit          m_block[2];

  gol_grid_engine #(.ROWS(8), .COLS(8), .WRAP(1), .STEP_DIV(1), .GEN_W(16)) dut_a (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready_a),
    .load_data(load_data), .step(step), .run(run), .state(state_a),
    .state_valid(state_valid_a), .generation(gen_a), .busy(busy_a),
    .still(still_a), .extinct(extinct_a), .halted(halted_a)
  );

  gol_grid_engine #(.ROWS(8), .COLS(8), .WRAP(0), .STEP_DIV(4), .GEN_W(4)) dut_b (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready_b),
    .load_data(load_data), .step(step), .run(run), .state(state_b),
    .state_valid(state_valid_b), .generation(gen_b), .busy(busy_b),
    .still(still_b), .extinct(extinct_b), .halted(halted_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [63:0] cellbit(input int r, input int c);
    return 64'(1) << (63 - (r * 8 + c));
  endfunction

  function automatic int alive(input logic [63:0] g, input int r, input int c);
    return ((g & cellbit(r, c)) != 0) ? 1 : 0;
  endfunction

  function automatic logic [63:0] life_next(input logic [63:0] g, input bit wrap);
    logic [63:0] n;
    int cnt, rr, cc;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
              if (wrap) cnt += alive(g, (rr + 8) % 8, (cc + 8) % 8);
              else if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) cnt += alive(g, rr, cc);
            end
          end
        end
        if (cnt == 3 || (cnt == 2 && alive(g, r, c) == 1)) n |= cellbit(r, c);
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int d);
    exp_t e;
    e.st  = m_state[d];
    e.gen = m_gen[d];
    e.cyc = cyc + 1;
    if (d == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = '0; m_gen[d] = 0; m_div[d] = 0;
      m_run[d] = 1'b0; m_halted[d] = 1'b0; m_block[d] = 1'b0;
    end
    qa.delete();
    qb.delete();
  endtask

  // What engine d does on the coming clock edge given the current inputs
  task automatic model_edge(input int d);
    logic [63:0] nx;
    nx = life_next(m_state[d], WR[d]);
    if (!m_run[d]) begin
      if (load_valid) begin
        m_state[d] = load_data; m_gen[d] = 0; m_halted[d] = 1'b0; m_block[d] = 1'b0;
        push_exp(d);
      end else if (run && !m_block[d]) begin
        m_run[d] = 1'b1; m_div[d] = 0;
      end else if (step) begin
        m_state[d] = nx; m_gen[d] = (m_gen[d] + 1) & GM[d];
        push_exp(d);
      end
      if (!run) m_block[d] = 1'b0;
    end else if (!run) begin
      m_run[d] = 1'b0;
      m_block[d] = 1'b0;
    end else if (m_div[d] == SD[d] - 1) begin
      m_div[d] = 0;
`ifdef GOL_AUTO_HALT_EN
      if (nx == m_state[d] || m_state[d] == 0) begin
        m_run[d] = 1'b0; m_halted[d] = 1'b1; m_block[d] = 1'b1;
      end else begin
        m_state[d] = nx; m_gen[d] = (m_gen[d] + 1) & GM[d];
        push_exp(d);
      end
`else
      m_state[d] = nx; m_gen[d] = (m_gen[d] + 1) & GM[d];
      push_exp(d);
`endif
    end else begin
      m_div[d]++;
    end
  endtask

  task automatic check_status(input int d);
    logic [63:0] nx;
    nx = life_next(m_state[d], WR[d]);
    if (d == 0) begin
      chk("a_busy", 64'(busy_a), 64'(m_run[0]));
      chk("a_load_ready", 64'(load_ready_a), 64'(!m_run[0]));
      chk("a_halted", 64'(halted_a), 64'(m_halted[0]));
      chk("a_still", 64'(still_a), 64'(nx == m_state[0]));
      chk("a_extinct", 64'(extinct_a), 64'(m_state[0] == 0));
    end else begin
      chk("b_busy", 64'(busy_b), 64'(m_run[1]));
      chk("b_load_ready", 64'(load_ready_b), 64'(!m_run[1]));
      chk("b_halted", 64'(halted_b), 64'(m_halted[1]));
      chk("b_still", 64'(still_b), 64'(nx == m_state[1]));
      chk("b_extinct", 64'(extinct_b), 64'(m_state[1] == 0));
    end
  endtask

  task automatic tick(input bit lv, input logic [63:0] ld, input bit st, input bit rn);
    @(negedge clk);
    load_valid = lv; load_data = ld; step = st; run = rn;
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #2;
    check_status(0);
    check_status(1);
  endtask

  // Monitor: pop one expected update per state_valid pulse and compare grid, count and timing
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (state_valid_a) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_valid", 64'(1), 64'(0));
        end else begin
          e = qa.pop_front();
          chk("a_state", state_a, e.st);
          chk("a_generation", 64'(gen_a), 64'(e.gen));
          chk("a_valid_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (state_valid_b) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_valid", 64'(1), 64'(0));
        end else begin
          e = qb.pop_front();
          chk("b_state", state_b, e.st);
          chk("b_generation", 64'(gen_b), 64'(e.gen));
          chk("b_valid_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    logic [63:0] pat, glider, block;
    bit rn;
    rst = 1'b1; load_valid = 1'b0; load_data = '0; step = 1'b0; run = 1'b0;
    model_reset();
    #22;
    chk("rst_state_a", state_a, 64'(0));
    chk("rst_gen_a", 64'(gen_a), 64'(0));
    chk("rst_valid_a", 64'(state_valid_a), 64'(0));
    chk("rst_busy_a", 64'(busy_a), 64'(0));
    chk("rst_halted_a", 64'(halted_a), 64'(0));
    chk("rst_state_b", state_b, 64'(0));
    chk("rst_busy_b", 64'(busy_b), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    tick(0, '0, 0, 0);

    // Blinker oscillates with period two
    pat = cellbit(3, 2) | cellbit(3, 3) | cellbit(3, 4);
    tick(1, pat, 0, 0);
    tick(0, '0, 1, 0);
    chk("blinker_a_gen1", state_a, cellbit(2, 3) | cellbit(3, 3) | cellbit(4, 3));
    chk("blinker_b_gen1", state_b, cellbit(2, 3) | cellbit(3, 3) | cellbit(4, 3));
    chk("blinker_a_count1", 64'(gen_a), 64'(1));
    tick(0, '0, 1, 0);
    chk("blinker_a_gen2", state_a, pat);
    chk("blinker_a_count2", 64'(gen_a), 64'(2));
    tick(0, '0, 0, 0);

    // Row on the top edge: torus versus dead border
    pat = cellbit(0, 0) | cellbit(0, 1) | cellbit(0, 2);
    tick(1, pat, 0, 0);
    tick(0, '0, 1, 0);
    chk("edge_wrap_a", state_a, cellbit(7, 1) | cellbit(0, 1) | cellbit(1, 1));
    chk("edge_dead_b", state_b, cellbit(0, 1) | cellbit(1, 1));

    // Glider returns home after 32 generations on the 8x8 torus
    glider = cellbit(0, 1) | cellbit(1, 2) | cellbit(2, 0) | cellbit(2, 1) | cellbit(2, 2);
    tick(1, glider, 0, 0);
    tick(0, '0, 0, 1);
    for (int i = 0; i < 32; i++) tick(i[0], '1, i[1], 1);
    tick(0, '0, 0, 0);
    chk("glider_a_home", state_a, glider);
    chk("glider_a_gen32", 64'(gen_a), 64'(32));
    tick(0, '0, 0, 0);

    // Rate divider with ignored loads, then leaving RUN with no extra advance
    tick(1, pat | cellbit(5, 5) | cellbit(5, 6) | cellbit(5, 7), 0, 0);
    for (int i = 0; i < 18; i++) tick(i > 0, '1, 1, 1);
    tick(0, '0, 1, 0);
    tick(0, '0, 0, 0);

    // Still life: block at (3,3)
    block = cellbit(3, 3) | cellbit(3, 4) | cellbit(4, 3) | cellbit(4, 4);
    tick(1, block, 0, 0);
    chk("block_still_a", 64'(still_a), 64'(1));
    chk("block_extinct_a", 64'(extinct_a), 64'(0));
    for (int i = 0; i < 12; i++) tick(0, '0, 0, 1);
    tick(0, '0, 0, 0);
    tick(0, '0, 0, 1);
    tick(0, '0, 0, 0);

    // Randomised mix of loads, steps and runs
    rn = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) rn = !rn;
      tick($urandom_range(0, 11) == 0, {$urandom & $urandom, $urandom & $urandom},
           $urandom_range(0, 2) == 0, rn);
    end
    tick(0, '0, 0, 0);

    // Asynchronous reset while running
    tick(1, cellbit(3, 2) | cellbit(3, 3) | cellbit(3, 4), 0, 0);
    for (int i = 0; i < 6; i++) tick(0, '0, 0, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_state_a", state_a, 64'(0));
    chk("midrst_gen_a", 64'(gen_a), 64'(0));
    chk("midrst_busy_a", 64'(busy_a), 64'(0));
    chk("midrst_valid_a", 64'(state_valid_a), 64'(0));
    chk("midrst_state_b", state_b, 64'(0));
    chk("midrst_busy_b", 64'(busy_b), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    tick(1, cellbit(3, 2) | cellbit(3, 3) | cellbit(3, 4), 0, 0);
    tick(0, '0, 1, 0);
    chk("post_rst_step_a", state_a, cellbit(2, 3) | cellbit(3, 3) | cellbit(4, 3));
    for (int i = 0; i < 3; i++) tick(0, '0, 0, 0);

    chk("a_queue_drained", 64'(qa.size()), 64'(0));
    chk("b_queue_drained", 64'(qb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
